// File: rtl/present_key_sched_ctrl.sv
// PRESENT-80 key-schedule sequencer: loads a master key, streams K1..K32 with backpressure.
// Optional KSCHED_ABORT_EN adds an abort input that drops a running schedule.
module present_key_sched_ctrl #(
    parameter int KEY_W  = 80,
    parameter int RK_W   = 64,
    parameter int NUM_RK = 32,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [CNT_W-1:0] rk_idx,
`ifdef KSCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_RK - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_p0, state_nxt;
    logic [KEY_W-1:0]   key_p0, key_nxt;
    logic [CNT_W-1:0]   idx_p0, idx_nxt;
    logic               done_p0, done_nxt;
    logic               abort_req;

`ifdef KSCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One round of the key update: rotate left 61, S-box the top nibble, salt with the round number.
    function automatic logic [KEY_W-1:0] upd(input logic [KEY_W-1:0] k,
                                             input logic [CNT_W-1:0] i);
        logic [KEY_W-1:0] t;
        t = {k[18:0], k[KEY_W-1:19]};
        t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
        t[15 +: CNT_W] = t[15 +: CNT_W] ^ i;
        return t;
    endfunction

    always_comb begin
        state_nxt = state_p0;
        key_nxt   = key_p0;
        idx_nxt   = idx_p0;
        done_nxt  = 1'b0;
        if (state_p0 == IDLE) begin
            if (key_valid) begin
                key_nxt   = key_in;
                idx_nxt   = '0;
                state_nxt = RUN;
            end
        end else begin
            // Abort takes priority over a round-key handshake in the same cycle.
            if (abort_req) begin
                key_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end else if (rk_ready) begin
                if (idx_p0 == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    key_nxt = upd(key_p0, idx_p0 + 1'b1);
                    idx_nxt = idx_p0 + 1'b1;
                end
            end
        end
    end

    // Stage p0: working key, round index, state and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            key_p0   <= '0;
            idx_p0   <= '0;
            done_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            key_p0   <= key_nxt;
            idx_p0   <= idx_nxt;
            done_p0  <= done_nxt;
        end
    end

    assign key_ready = (state_p0 == IDLE);
    assign rk_valid  = (state_p0 == RUN);
    assign busy      = (state_p0 == RUN);
    assign rk_data   = key_p0[KEY_W-1 -: RK_W];
    assign rk_idx    = idx_p0;
    assign done      = done_p0;

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Randomised bench for present_key_sched_ctrl against a high-level PRESENT-80 key schedule model.
// Abort scenario is exercised only when KSCHED_ABORT_EN is defined.
module tb_present_key_sched_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [79:0] key_in;
    logic        rk_valid;
    logic        rk_ready;
    logic [63:0] rk_data;
    logic [4:0]  rk_idx;
    logic        busy;
    logic        done;
`ifdef KSCHED_ABORT_EN
    logic        abort;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [63:0] exp_rk [32];
    logic [63:0] obs_rk [32];

    present_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
`ifdef KSCHED_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] sbox_ref(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[(15 - int'(x)) * 4 +: 4];
    endfunction

    // Builds the 32 expected round keys straight from the PRESENT-80 key schedule rules.
    task automatic build_model(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        for (int i = 0; i < 32; i++) begin
            exp_rk[i] = k[79:16];
            k = (k << 61) | (k >> 19);
            k[79:76] = sbox_ref(k[79:76]);
            k = k ^ (80'(i + 1) << 15);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [79:0] k);
        int waited;
        key_in    = k;
        key_valid = 1'b1;
        waited    = 0;
        while (!key_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!key_ready) check("key_accept_timeout", 1, 0);
        tick();
        key_valid = 1'b0;
    endtask

    // Consumes round keys, checking each cycle; returns early once stop_at keys are taken.
    task automatic drain(input logic [79:0] k, input bit stall, input int stop_at);
        int n;
        int budget;
        build_model(k);
        n = 0;
        budget = 0;
        while (n < 32 && n != stop_at && budget < 2000) begin
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            check("rk_valid", rk_valid, 1);
            check("busy", busy, 1);
            check("key_ready_run", key_ready, 0);
            check("done_low", done, 0);
            check("rk_data", rk_data, exp_rk[n]);
            check("rk_idx", rk_idx, n);
            if (rk_ready) obs_rk[n] = rk_data;
            tick();
            if (rk_ready) n++;
            budget++;
        end
        rk_ready = 1'b0;
        if (budget >= 2000) check("drain_timeout", 1, 0);
        if (n == 32) begin
            check("done_pulse", done, 1);
            check("key_ready_done", key_ready, 1);
            check("rk_valid_done", rk_valid, 0);
            check("busy_done", busy, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_rk_valid"}, rk_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rk_data"}, rk_data, 0);
        check({tag, "_rk_idx"}, rk_idx, 0);
    endtask

    initial begin
        logic [79:0] rkey;
        logic [79:0] rkey2;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
`ifdef KSCHED_ABORT_EN
        abort     = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Zero key, no stalls: known vectors
        send_key(80'h0);
        drain(80'h0, 1'b0, -1);
        check("K1_zero", obs_rk[0], 64'h0000000000000000);
        check("K2_zero", obs_rk[1], 64'hC000000000000000);
        check("K32_zero", obs_rk[31], 64'h6DAB31744F41D700);
        tick();
        check("done_one_cycle", done, 0);

        // Zero key with random stalls
        send_key(80'h0);
        drain(80'h0, 1'b1, -1);
        check("K32_zero_stall", obs_rk[31], 64'h6DAB31744F41D700);
        tick();

        // All-ones key
        send_key({80{1'b1}});
        drain({80{1'b1}}, 1'b0, -1);
        check("K32_ones", obs_rk[31], 64'hFE7A548FB60EB167);
        tick();

        // Second key held while busy, accepted in the done cycle
        rkey  = {$urandom, $urandom, 16'($urandom)};
        rkey2 = {$urandom, $urandom, 16'($urandom)};
        send_key(rkey);
        key_in    = rkey2;
        key_valid = 1'b1;
        drain(rkey, 1'b1, -1);
        tick();
        key_valid = 1'b0;
        check("b2b_rk_valid", rk_valid, 1);
        check("b2b_rk_idx", rk_idx, 0);
        check("b2b_done_low", done, 0);
        drain(rkey2, 1'b1, -1);
        tick();

        // Reset mid-run at rk_idx 10
        rkey = {$urandom, $urandom, 16'($urandom)};
        send_key(rkey);
        drain(rkey, 1'b1, 10);
        check("pre_reset_idx", rk_idx, 10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");
        rkey = {$urandom, $urandom, 16'($urandom)};
        send_key(rkey);
        drain(rkey, 1'b1, -1);
        tick();

`ifdef KSCHED_ABORT_EN
        // Abort at rk_idx 5, coinciding with a handshake
        rkey = {$urandom, $urandom, 16'($urandom)};
        send_key(rkey);
        drain(rkey, 1'b0, 5);
        rk_ready = 1'b1;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        rk_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("abort_rk_valid", rk_valid, 0);
            check("abort_key_ready", key_ready, 1);
            check("abort_done", done, 0);
            check("abort_rk_data", rk_data, 0);
            tick();
        end
        abort = 1'b1;
        check("abort_idle_ready", key_ready, 1);
        rkey = {$urandom, $urandom, 16'($urandom)};
        send_key(rkey);
        abort = 1'b0;
        check("abort_idle_ignored", rk_valid, 1);
        drain(rkey, 1'b1, -1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
